// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front end.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC            = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Instructions are word aligned; the low two address bits carry no meaning.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular buffer of fetched {pc, instr} entries; head is shown from registered state.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];

  // Flush shares the reset path so a redirect leaves no partial queue state.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && !flush && do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, issues memory requests, queues returned words.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT,
  parameter int          QDEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] iaddrbus,
  output logic        ireq,
  input  logic [31:0] ibus,
  input  logic        iack,
  input  logic        stall_id,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ibus_id,
  output logic [31:0] pc_id,
  output logic        valid_id
);

  localparam int CW = ((QDEPTH > 1) ? $clog2(QDEPTH) : 1) + 1;

  logic [31:0]   fetch_pc_reg;
  fetch_entry_t  push_entry;
  fetch_entry_t  q_head;
  logic [CW-1:0] q_count;
  logic          q_full;
  logic          q_empty;
  logic          push;
  logic          pop;

  // Redirect suppresses the request so whatever memory returns that cycle is dropped.
  assign ireq       = reset_n && !redirect && (q_count < CW'(QDEPTH));
  assign push       = ireq && iack;
  assign pop        = !q_empty && !stall_id && !redirect;
  assign push_entry = '{pc: fetch_pc_reg, instr: ibus};

  assign iaddrbus = fetch_pc_reg;
  assign valid_id = !q_empty;
  assign ibus_id  = q_empty ? NOP_INSTR : q_head.instr;
  assign pc_id    = q_empty ? 32'h0000_0000 : q_head.pc;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_pc_reg <= RESET_PC;
    end else if (redirect) begin
      fetch_pc_reg <= align_pc(redirect_pc);
    end else if (push) begin
      fetch_pc_reg <= fetch_pc_reg + PC_INC;
    end
  end

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  no_push_when_full: assert property (@(posedge clk) q_full |-> !push);

endmodule
